siphash_core: RTL and testbench

- Iterative SipHash-c-d controller. Owns the four 64-bit state registers and sequences one `sip_round` instance, one round per clock.
- Absorbs pre-padded 64-bit message words over a valid/ready stream, then runs finalization.
- Presents the 64-bit tag on a valid/ready output.
- Sits between the host/DMA word stream and the MAC consumers; padding and length byte are inserted upstream.

---
 rtl/siphash_pkg.sv | 31 +++
 rtl/siphash_round.sv | 27 ++
 rtl/siphash_core.sv | 142 ++++++++++++++
 tb/tb_siphash_core.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_pkg.sv
// Shared SipHash constants, state encoding and round payload type.
package siphash_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [63:0] INIT0   = 64'h736f6d6570736575;
    localparam logic [63:0] INIT1   = 64'h646f72616e646f6d;
    localparam logic [63:0] INIT2   = 64'h6c7967656e657261;
    localparam logic [63:0] INIT3   = 64'h7465646279746573;
    localparam logic [63:0] FIN_XOR = 64'h00000000000000ff;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COMP,
        ST_FIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [63:0] v3;
        logic [63:0] v2;
        logic [63:0] v1;
        logic [63:0] v0;
    } sip_state_t;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound over the four 64-bit state words.
module sip_round
    import siphash_pkg::*;
(
    input  sip_state_t v_i,
    output sip_state_t v_o_c
);

    logic [63:0] a0, a1, b0, a2, a3, c0, c3, c2, c1;

    always_comb begin
        a0 = v_i.v0 + v_i.v1;
        a1 = rotl(v_i.v1, 13) ^ a0;
        b0 = rotl(a0, 32);
        a2 = v_i.v2 + v_i.v3;
        a3 = rotl(v_i.v3, 16) ^ a2;
        c0 = b0 + a3;
        c3 = rotl(a3, 21) ^ c0;
        c2 = a2 + a1;
        c1 = rotl(a1, 17) ^ c2;
        v_o_c.v0 = c0;
        v_o_c.v1 = c1;
        v_o_c.v2 = rotl(c2, 32);
        v_o_c.v3 = c3;
    end

endmodule

// File: rtl/siphash_core.sv
// Iterative SipHash-c-d: absorbs padded 64-bit words, one round per clock, emits the tag.
module siphash_core
    import siphash_pkg::*;
#(
    parameter int unsigned C_ROUNDS = 2,
    parameter int unsigned D_ROUNDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   hash,
    output logic          busy
);

    if (C_ROUNDS < 1 || C_ROUNDS > 15) begin : g_bad_c
        $error("siphash_core: C_ROUNDS must be 1..15");
    end
    if (D_ROUNDS < 1 || D_ROUNDS > 15) begin : g_bad_d
        $error("siphash_core: D_ROUNDS must be 1..15");
    end

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_ROUNDS - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_ROUNDS - 1);

    state_e           state_q, state_d;
    sip_state_t       v_q, v_d, rnd_c;
    logic [63:0]      m_q, m_d;
    logic [63:0]      hash_q, hash_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    sip_round u_round (
        .v_i   (v_q),
        .v_o_c (rnd_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            m_q         <= '0;
            hash_q      <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            m_q         <= m_d;
            hash_q      <= hash_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        m_d     = m_q;
        hash_d  = hash_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    v_d.v0  = key[63:0]   ^ INIT0;
                    v_d.v1  = key[127:64] ^ INIT1;
                    v_d.v2  = key[63:0]   ^ INIT2;
                    v_d.v3  = key[127:64] ^ INIT3 ^ in_data;
                    m_d     = in_data;
                    last_d  = in_last;
                    cnt_d   = '0;
                    state_d = ST_COMP;
                end
            end
            ST_WAIT: begin
                if (in_valid) begin
                    v_d.v3  = v_q.v3 ^ in_data;
                    m_d     = in_data;
                    last_d  = in_last;
                    cnt_d   = '0;
                    state_d = ST_COMP;
                end
            end
            ST_COMP: begin
                v_d   = rnd_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    v_d.v0 = rnd_c.v0 ^ m_q;
                    cnt_d  = '0;
                    if (last_q) begin
                        v_d.v2  = rnd_c.v2 ^ FIN_XOR;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_FIN: begin
                v_d   = rnd_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == D_LAST) begin
                    hash_d  = rnd_c.v0 ^ rnd_c.v1 ^ rnd_c.v2 ^ rnd_c.v3;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Tag is presented one cycle after entering DONE and drops on the accepting edge.
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_WAIT);
        busy_d      = (state_d == ST_COMP) || (state_d == ST_FIN) || (state_d == ST_DONE);
        out_valid_d = (state_q == ST_DONE) && !(out_valid_q && out_ready);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign hash      = hash_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_siphash_core.sv
// Scoreboard bench for siphash_core: a C=2/D=4 build and a C=1/D=3 build against a byte-level SipHash model.
module tb_siphash_core;

    typedef logic [7:0]  bq_t[$];
    typedef logic [63:0] wq_t[$];
    typedef struct {
        logic [63:0] h;
        time         acc;
        int          lat;
    } exp_t;

    localparam int CS [2] = '{2, 1};
    localparam int DS [2] = '{4, 3};
    localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a0908_0706050403020100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key       [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [63:0]  in_data   [2];
    logic         in_last   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [63:0]  hash      [2];
    logic         busy      [2];

    exp_t sb [2][$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    siphash_core #(.C_ROUNDS(2), .D_ROUNDS(4)) u_dut0 (
        .clk(clk), .rst(rst), .key(key[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .hash(hash[0]), .busy(busy[0])
    );

    siphash_core #(.C_ROUNDS(1), .D_ROUNDS(3)) u_dut1 (
        .clk(clk), .rst(rst), .key(key[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .hash(hash[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic void sround(inout logic [63:0] a, inout logic [63:0] b,
                                   inout logic [63:0] c, inout logic [63:0] d);
        a += b; b = rl(b, 13); b ^= a; a = rl(a, 32);
        c += d; d = rl(d, 16); d ^= c;
        a += d; d = rl(d, 21); d ^= a;
        c += b; b = rl(b, 17); b ^= c; c = rl(c, 32);
    endfunction

    // Upstream padding: little-endian words, final word carries the byte length in its top byte.
    function automatic wq_t pack(input bq_t m);
        wq_t w;
        logic [63:0] x;
        int n = m.size();
        for (int i = 0; i <= n / 8; i++) begin
            x = '0;
            for (int b = 0; b < 8; b++)
                if (i * 8 + b < n) x[8*b +: 8] = m[i*8 + b];
            if (i == n / 8) x[63:56] = 8'(n);
            w.push_back(x);
        end
        return w;
    endfunction

    function automatic logic [63:0] ref_hash(input logic [127:0] k, input bq_t m,
                                             input int c, input int d);
        wq_t w = pack(m);
        logic [63:0] v0, v1, v2, v3;
        v0 = k[63:0]   ^ 64'h736f6d6570736575;
        v1 = k[127:64] ^ 64'h646f72616e646f6d;
        v2 = k[63:0]   ^ 64'h6c7967656e657261;
        v3 = k[127:64] ^ 64'h7465646279746573;
        foreach (w[i]) begin
            v3 ^= w[i];
            repeat (c) sround(v0, v1, v2, v3);
            v0 ^= w[i];
        end
        v2 ^= 64'hff;
        repeat (d) sround(v0, v1, v2, v3);
        return v0 ^ v1 ^ v2 ^ v3;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_word(input int u, input logic [63:0] d, input logic last,
                             input logic [127:0] k, output time acc, output int nr);
        in_data[u] = d; in_last[u] = last; key[u] = k; in_valid[u] = 1'b1;
        nr = 0; acc = 0;
        for (int i = 0; i < 200 && !in_ready[u]; i++) begin
            nr++;
            @(negedge clk);
        end
        if (!in_ready[u]) begin
            errors++; checks++;
            $display("FAIL accept_timeout unit %0d: in_ready stayed 0", u);
            in_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        acc = $time;
        @(negedge clk);
        in_valid[u] = 1'b0;
        key[u] = rand_key();
    endtask

    task automatic send_msg(input int u, input logic [127:0] k, input bq_t m,
                            input int gap, input logic [63:0] exp_h);
        wq_t  w = pack(m);
        time  acc;
        int   nr;
        exp_t e;
        foreach (w[i]) begin
            send_word(u, w[i], i == w.size() - 1, (i == 0) ? k : rand_key(), acc, nr);
            if (i > 0 && gap == 0) chk("ready_low_cycles", 64'(nr), 64'(CS[u]));
            if (i == w.size() - 1) begin
                e.h = exp_h; e.acc = acc; e.lat = CS[u] + DS[u] + 1;
                sb[u].push_back(e);
            end
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int u);
        int ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (sb[u].size() == 0 && in_ready[u]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL drain_timeout unit %0d: pending=%0d required=0", u, sb[u].size());
            sb[u].delete();
        end
    endtask

    task automatic chk_reset_outputs(input int u);
        chk("rst_in_ready",  64'(in_ready[u]),  64'(1));
        chk("rst_out_valid", 64'(out_valid[u]), 64'(0));
        chk("rst_busy",      64'(busy[u]),      64'(0));
        chk("rst_hash",      hash[u],           64'(0));
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic        ov_prev = 1'b0;
        logic [63:0] h_prev  = '0;
        always @(negedge clk) begin
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                chk("busy_vs_ready", 64'(busy[g]), 64'(!in_ready[g]));
                if (out_valid[g] && !ov_prev) begin
                    if (sb[g].size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_tag unit %0d: out_valid=1 required=0", g);
                    end else begin
                        chk("tag_latency", 64'(($time - 5 - sb[g][0].acc) / 10), 64'(sb[g][0].lat));
                    end
                end
                if (out_valid[g] && ov_prev) chk("hash_stable", hash[g], h_prev);
                if (out_valid[g] && out_ready[g] && sb[g].size() != 0) begin
                    chk("tag_value", hash[g], sb[g][0].h);
                    void'(sb[g].pop_front());
                end
                ov_prev = out_valid[g];
                h_prev  = hash[g];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t e0, m8, mr;
        logic [127:0] k;
        logic [63:0]  eh;
        for (int u = 0; u < 2; u++) begin
            key[u] = '0; in_valid[u] = 1'b0; in_data[u] = '0;
            in_last[u] = 1'b0; out_ready[u] = 1'b1;
        end
        for (int i = 0; i < 8; i++) m8.push_back(8'(i));

        repeat (2) @(negedge clk);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);

        // Published vectors: empty message and 8-byte message.
        send_msg(0, KEY0, e0, 0, 64'h726fdb47dd0e0e31);
        wait_done(0);
        send_msg(0, KEY0, m8, 0, 64'h93f5f5799a932462);
        wait_done(0);

        // Back-pressure on the tag, then a fresh key.
        out_ready[0] = 1'b0;
        mr.delete();
        repeat (11) mr.push_back(8'($urandom));
        k  = rand_key();
        eh = ref_hash(k, mr, 2, 4);
        send_msg(0, k, mr, 0, eh);
        for (int i = 0; i < 100 && !out_valid[0]; i++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid[0]), 64'(1));
            chk("hold_in_ready",  64'(in_ready[0]),  64'(0));
            chk("hold_hash",      hash[0],           eh);
        end
        out_ready[0] = 1'b1;
        wait_done(0);
        k = rand_key();
        send_msg(0, k, m8, 0, ref_hash(k, m8, 2, 4));
        wait_done(0);

        // Idle gaps between words must not change the tag.
        send_msg(0, KEY0, m8, 5, 64'h93f5f5799a932462);
        wait_done(0);

        // Asynchronous reset during finalization discards the message.
        send_msg(0, KEY0, e0, 0, 64'h726fdb47dd0e0e31);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs(0);
        sb[0].delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        send_msg(0, KEY0, e0, 0, 64'h726fdb47dd0e0e31);
        wait_done(0);

        // C=1/D=3 build: empty message against the model.
        send_msg(1, KEY0, e0, 0, ref_hash(KEY0, e0, 1, 3));
        wait_done(1);

        // Random lengths, keys and gaps on both builds concurrently.
        fork
            for (int n = 0; n < 8; n++) begin
                bq_t m; logic [127:0] kk; int gp;
                repeat ($urandom_range(0, 20)) m.push_back(8'($urandom));
                kk = rand_key(); gp = $urandom_range(0, 2);
                send_msg(0, kk, m, gp, ref_hash(kk, m, CS[0], DS[0]));
                wait_done(0);
            end
            for (int n = 0; n < 8; n++) begin
                bq_t m; logic [127:0] kk; int gp;
                repeat ($urandom_range(0, 20)) m.push_back(8'($urandom));
                kk = rand_key(); gp = $urandom_range(0, 2);
                send_msg(1, kk, m, gp, ref_hash(kk, m, CS[1], DS[1]));
                wait_done(1);
            end
        join

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
